// File: rtl/btn_debounce_pkg.sv
// Shared types and width helpers for the button debounce block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } deb_state_t;

    // Width needed to hold values 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_pulse_sync.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: STAGES rising edges from input change to q.
// Backpressure: none; free-running shift chain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw level through the chain; only the last stage is used downstream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/btn_debounce_pulse.sv
// Debounces a raw push-button into a clean level plus press/release/auto-repeat pulses.
// Latency: SYNC_STAGES+STABLE_CYCLES edges from a clean raw edge to its press/release pulse.
// Backpressure: none; pulses are single-cycle and must be consumed when emitted.
module btn_debounce_pulse
    import btn_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat,
    output logic btn_tick
);

    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam int HW = cnt_width(max2(HOLD_CYCLES, REPEAT_CYCLES) + 1);

    localparam logic [CW-1:0] CNT_LAST    = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_CYCLES - 1);

    logic       s;
    deb_state_t state_q;
    logic [CW-1:0] cnt_q;
    logic [HW-1:0] hcnt_q;
    logic [HW-1:0] hcnt_last;
    logic       armed_q;     // first repeat already issued; later ones use REPEAT spacing
    logic       level_q;
    logic       press_q;
    logic       release_q;
    logic       repeat_q;
    logic       tick_q;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (s)
    );

    // Terminal count for the hold timer: initial hold delay, then the repeat period.
    always_comb begin
        hcnt_last = armed_q ? REPEAT_LAST : HOLD_LAST;
    end

    // Debounce FSM, hold/repeat timer and registered outputs in one block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE_LOW;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            armed_q   <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            // Pulses default low; the hold timer only survives in IDLE_HIGH.
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            tick_q    <= 1'b0;
            hcnt_q    <= '0;
            armed_q   <= 1'b0;
            case (state_q)
                IDLE_LOW: begin
                    if (s) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                        tick_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!s) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= CNT_ONE;
                    end else if (hcnt_q == hcnt_last) begin
                        armed_q  <= 1'b1;
                        repeat_q <= 1'b1;
                        tick_q   <= 1'b1;
                    end else begin
                        hcnt_q  <= hcnt_q + HW'(1);
                        armed_q <= armed_q;
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        // Bounce during a hold: back to high, timer restarts, no pulse.
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= IDLE_LOW;
                        cnt_q     <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE_LOW;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;
    assign btn_tick    = tick_q;

endmodule

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
- Conditions a raw, bouncy push-button into clean single-cycle pulses.
- Sits directly upstream of contador_Nbits and gates its count advance, so each physical press produces exactly one increment.
- Also provides hold-to-auto-repeat pulses for fast counting.
- Contains a synchronizer, a 4-state debounce FSM and a hold/repeat timer.

Parameters:
- SYNC_STAGES, 2: number of metastability flops on btn_in (>=2).
- STABLE_CYCLES, 4: consecutive identical synchronized samples required to accept a level change (>=2; board value 1_000_000).
- HOLD_CYCLES, 8: cycles the button must stay accepted-high before the first repeat pulse (>=1).
- REPEAT_CYCLES, 3: cycles between successive repeat pulses (>=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- btn_in  input  1  raw asynchronous button level, active-high.
- btn_level  output  1  debounced button level.
- btn_press  output  1  one-cycle pulse on an accepted rising level.
- btn_release  output  1  one-cycle pulse on an accepted falling level.
- btn_repeat  output  1  one-cycle pulse per auto-repeat interval while held.
- btn_tick  output  1  btn_press OR btn_repeat; the count-enable for the downstream counter.

Behaviour:
- Reset (reset=0, asynchronous):
  - synchronizer flops=0, FSM=IDLE_LOW, sample and hold counters=0.
  - all outputs=0.
  - Deassertion takes effect on the next rising edge.
- Synchronizer: btn_in passes through SYNC_STAGES flops; the FSM sees only s = the last stage.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW (enum in package). Sample counter cnt has width $clog2(STABLE_CYCLES).
  - IDLE_LOW: if s=1, go to WAIT_HIGH with cnt=1. Otherwise stay.
  - WAIT_HIGH: if s=0, go to IDLE_LOW with cnt=0. If s=1 and cnt==STABLE_CYCLES-1, go to IDLE_HIGH. Otherwise cnt++.
  - IDLE_HIGH: if s=0, go to WAIT_LOW with cnt=1. Otherwise stay.
  - WAIT_LOW: if s=1, go to IDLE_HIGH with cnt=0 and no pulse. If s=0 and cnt==STABLE_CYCLES-1, go to IDLE_LOW. Otherwise cnt++.
- Outputs are all registered:
  - btn_level=1 in IDLE_HIGH and WAIT_LOW.
  - btn_press=1 for exactly the cycle after the WAIT_HIGH to IDLE_HIGH edge; btn_level rises in the same cycle.
  - btn_release=1 for exactly the cycle after the WAIT_LOW to IDLE_LOW edge; btn_level falls in the same cycle.
- Latency: a clean raw edge produces its press/release pulse SYNC_STAGES+STABLE_CYCLES rising edges after the first edge sampling the new level. With defaults this is 6.
- Glitch rejection: a run of fewer than STABLE_CYCLES identical samples returns the FSM to the previous idle state with no output change.
- Hold/repeat timer hcnt has width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1).
  - Cleared on entry to IDLE_HIGH and in every other state.
  - In IDLE_HIGH it counts cycles since the press pulse.
  - The first btn_repeat occurs HOLD_CYCLES cycles after btn_press. Subsequent pulses occur every REPEAT_CYCLES cycles while in IDLE_HIGH.
- Bounce during a hold (IDLE_HIGH to WAIT_LOW and back): the timer restarts from 0 on return, with no press pulse. Repeats resume HOLD_CYCLES later.
- btn_press and btn_repeat are never high in the same cycle. At most one of press/release/repeat is high per cycle.
- Button held through reset deassertion: treated as a fresh rise. A press pulse follows after full qualification.
- Reset mid-WAIT or mid-repeat: all counters and the FSM clear, and no pulse is emitted.

Decomposition:
- Package btn_debounce_pkg:
  - typedef enum logic [1:0] deb_state_t {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW}.
  - Localparam helper for counter widths.
- Sub-module sync_ff:
  - Parameter STAGES; ports clk, reset, d, q.
  - Async active-low clear.
  - Instantiated once for btn_in.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with btn_in=1, then release → all outputs 0 during reset. btn_press pulses 6 edges after release; btn_level=1 from then on.
2. Clean press: btn_in 0→1, held 20 cycles → btn_press exactly 1 cycle at edge 6. btn_repeat at edges 14, 17, 20. btn_tick pulses at 6, 14, 17, 20.
3. Bounce rejection: btn_in toggles 1,0,1,1,0 per cycle then stays 0 → btn_press, btn_level and btn_tick remain 0 throughout.
4. Release: from accepted-high, btn_in 1→0 stable → btn_release 1 cycle at edge 6, btn_level falls in that cycle, no repeat after.
5. Bounce during hold: held-high 10 cycles, 2-cycle low glitch, then high → no release and no press. btn_level stays 1. Next btn_repeat appears 8 cycles after return to IDLE_HIGH.
6. Reset mid-operation: pull reset low during WAIT_HIGH (edge 4 of a press) → outputs stay 0, no pulse. After release with btn_in=0, outputs remain idle.
